// File: rtl/priority_decoder.sv
`default_nettype none
// ============================================================================
// Module   : priority_decoder
// Function : Rebuilds a one-hot or thermometer vector from a bit index by
//            iterative shifting, with the start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module priority_decoder #(
    parameter int DATA_LEN   = 8,
    parameter int RESULT_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dut_start,
    output logic                  dut_ready,
    output logic                  dut_done,
    input  logic [RESULT_LEN-1:0] idx_in,
    input  logic                  zero_in,
    input  logic                  mode_in,
    output logic [DATA_LEN-1:0]   data_out,
    output logic                  err_f
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // One extra bit so DATA_LEN itself is representable for the range check.
    localparam logic [RESULT_LEN:0] c_DATA_LEN = (RESULT_LEN + 1)'(DATA_LEN);
    localparam logic [DATA_LEN-1:0] c_ONE      = DATA_LEN'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [RESULT_LEN-1:0] r_idx;
    logic                  r_zero;
    logic                  r_mode;
    logic [DATA_LEN-1:0]   r_work;
    logic [DATA_LEN-1:0]   w_work_next;
    logic [RESULT_LEN-1:0] r_cnt;
    logic [RESULT_LEN-1:0] w_cnt_next;
    logic                  w_err;
    logic                  w_load_out;
    logic [DATA_LEN-1:0]   r_data_out;
    logic                  r_err;

    always_comb begin
        w_err        = ({1'b0, r_idx} >= c_DATA_LEN);
        w_cnt_next   = r_cnt + 1'b1;
        w_work_next  = r_work;
        w_state_next = r_state;
        w_load_out   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (dut_start) begin
                    w_state_next = c_LOAD;
                end
            end
            c_LOAD: begin
                w_work_next = c_ONE;
                if (r_zero || w_err || (r_idx == '0)) begin
                    w_state_next = c_DONE;
                    w_load_out   = 1'b1;
                end else begin
                    w_state_next = c_SHIFT;
                end
            end
            c_SHIFT: begin
                // Thermometer mode back-fills bit 0 on every shift.
                w_work_next = {r_work[DATA_LEN-2:0], 1'b0}
                            | {{(DATA_LEN-1){1'b0}}, r_mode};
                if (w_cnt_next == r_idx) begin
                    w_state_next = c_DONE;
                    w_load_out   = 1'b1;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_zero     <= 1'b0;
            r_mode     <= 1'b0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            if (r_state == c_IDLE && dut_start) begin
                r_idx  <= idx_in;
                r_zero <= zero_in;
                r_mode <= mode_in;
            end
            if (r_state == c_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == c_SHIFT) begin
                r_cnt <= w_cnt_next;
            end
            // Zero flag outranks an out-of-range index.
            if (w_load_out) begin
                if (r_zero) begin
                    r_data_out <= '0;
                    r_err      <= 1'b0;
                end else if (w_err) begin
                    r_data_out <= '0;
                    r_err      <= 1'b1;
                end else begin
                    r_data_out <= w_work_next;
                    r_err      <= 1'b0;
                end
            end
        end
    end

    assign dut_ready = (r_state == c_IDLE);
    assign dut_done  = (r_state == c_DONE);
    assign data_out  = r_data_out;
    assign err_f     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_priority_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_decoder
// Function : Directed self-checking bench for priority_decoder (8- and 6-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, zero_a = 1'b0, mode_a = 1'b0;
    logic [2:0] idx_a = 3'd0;
    logic       ready_a, done_a, err_a;
    logic [7:0] data_a;
    logic       start_b = 1'b0, zero_b = 1'b0, mode_b = 1'b0;
    logic [2:0] idx_b = 3'd0;
    logic       ready_b, done_b, err_b;
    logic [5:0] data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    priority_decoder #(.DATA_LEN(8), .RESULT_LEN(3)) u_dut_a (
        .clk(clk), .rst(rst), .dut_start(start_a), .dut_ready(ready_a),
        .dut_done(done_a), .idx_in(idx_a), .zero_in(zero_a), .mode_in(mode_a),
        .data_out(data_a), .err_f(err_a)
    );

    priority_decoder #(.DATA_LEN(6), .RESULT_LEN(3)) u_dut_b (
        .clk(clk), .rst(rst), .dut_start(start_b), .dut_ready(ready_b),
        .dut_done(done_b), .idx_in(idx_b), .zero_in(zero_b), .mode_in(mode_b),
        .data_out(data_b), .err_f(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int sel, input logic s, input logic [2:0] idx,
                         input logic z, input logic m);
        if (sel == 0) begin
            start_a = s; idx_a = idx; zero_a = z; mode_a = m;
        end else begin
            start_b = s; idx_b = idx; zero_b = z; mode_b = m;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic [7:0] get_data(input int sel);
        return (sel == 0) ? data_a : {2'b00, data_b};
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? err_a : err_b;
    endfunction

    function automatic int msb_idx(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Cycle 0 is the cycle start is presented in; pulse_at > 0 re-pulses
    // start with different inputs in that cycle.
    task automatic run_op(input int sel, input logic [2:0] idx, input logic zero,
                          input logic mode, input int pulse_at, input int exp_lat,
                          input logic [7:0] exp_data, input logic exp_err,
                          input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, get_ready(sel)}, 32'd1);
        drive(sel, 1'b1, idx, zero, mode);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (get_done(sel)) seen = 1;
            if (cyc == pulse_at) drive(sel, 1'b1, ~idx, zero, ~mode);
            else                 drive(sel, 1'b0, idx, zero, mode);
        end
        check({tag, "_lat"}, seen ? cyc : -1, exp_lat);
        check({tag, "_data"}, {24'd0, get_data(sel)}, {24'd0, exp_data});
        check({tag, "_err"}, {31'd0, get_err(sel)}, {31'd0, exp_err});
    endtask

    logic [7:0] rt_vec [6] = '{8'h2C, 8'h01, 8'hFF, 8'h00, 8'h91, 8'h46};
    logic [7:0] rt_exp [6] = '{8'h20, 8'h01, 8'h80, 8'h00, 8'h80, 8'h40};

    initial begin : stim
        int n_done;
        int d1, d2;
        bit r5, r10;
        logic [7:0] v;
        bit z;
        int ix;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready_a", {31'd0, ready_a}, 32'd1);
        check("rst_done_a",  {31'd0, done_a},  32'd0);
        check("rst_data_a",  {24'd0, data_a},  32'h00);
        check("rst_err_a",   {31'd0, err_a},   32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd1);
        check("rst_data_b",  {26'd0, data_b},  32'h00);

        // One-hot sweep
        run_op(0, 3'd5, 1'b0, 1'b0, 0, 7, 8'h20, 1'b0, "oh5");
        run_op(0, 3'd0, 1'b0, 1'b0, 0, 2, 8'h01, 1'b0, "oh0");
        run_op(0, 3'd7, 1'b0, 1'b0, 0, 9, 8'h80, 1'b0, "oh7");
        run_op(0, 3'd1, 1'b0, 1'b0, 0, 3, 8'h02, 1'b0, "oh1");

        // Thermometer
        run_op(0, 3'd3, 1'b0, 1'b1, 0, 5, 8'h0F, 1'b0, "th3");
        run_op(0, 3'd7, 1'b0, 1'b1, 0, 9, 8'hFF, 1'b0, "th7");
        run_op(0, 3'd0, 1'b0, 1'b1, 0, 2, 8'h01, 1'b0, "th0");

        // Zero flag and out-of-range on the 6-bit instance
        run_op(0, 3'd6, 1'b1, 1'b0, 0, 2, 8'h00, 1'b0, "zero6");
        run_op(1, 3'd7, 1'b0, 1'b0, 0, 2, 8'h00, 1'b1, "b_err7");
        run_op(1, 3'd5, 1'b0, 1'b1, 0, 7, 8'h3F, 1'b0, "b_th5");
        run_op(1, 3'd6, 1'b0, 1'b0, 0, 2, 8'h00, 1'b1, "b_err6");
        run_op(1, 3'd7, 1'b1, 1'b0, 0, 2, 8'h00, 1'b0, "b_zero_prio");
        run_op(1, 3'd4, 1'b0, 1'b0, 0, 6, 8'h10, 1'b0, "b_oh4");

        // Start pulsed during SHIFT is ignored
        run_op(0, 3'd5, 1'b0, 1'b0, 3, 7, 8'h20, 1'b0, "pulse");

        // Start held high: done at 4, ready at 5, done at 9, ready at 10, done at 14
        @(negedge clk);
        drive(0, 1'b1, 3'd2, 1'b0, 1'b0);
        n_done = 0; d1 = -1; d2 = -1; r5 = 0; r10 = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done_a) begin
                n_done++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 5)  r5  = ready_a;
            if (c == 10) r10 = ready_a;
            if (c == 11) start_a = 1'b0;
        end
        check("held_d1",    d1, 4);
        check("held_d2",    d2, 9);
        check("held_r5",    {31'd0, r5},  32'd1);
        check("held_r10",   {31'd0, r10}, 32'd1);
        check("held_count", n_done, 3);
        check("held_data",  {24'd0, data_a}, 32'h04);

        // Reset in the second SHIFT cycle of an idx 6 operation
        @(negedge clk);
        drive(0, 1'b1, 3'd6, 1'b0, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", {31'd0, ready_a}, 32'd1);
        check("mid_rst_done",  {31'd0, done_a},  32'd0);
        check("mid_rst_data",  {24'd0, data_a},  32'h00);
        check("mid_rst_err",   {31'd0, err_a},   32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        check("mid_rst_nodone", n_done, 0);

        // Round trip from encoder-style results
        for (int k = 0; k < 6; k++) begin
            v  = rt_vec[k];
            z  = (v == 8'h00);
            ix = msb_idx(v);
            run_op(0, ix[2:0], z, 1'b0, 0, z ? 2 : ix + 2, rt_exp[k], 1'b0,
                   $sformatf("rt%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_decoder.md
Name: priority_decoder

Overview:
- Inverse of the team's priority encoder: takes a bit index plus a zero flag and rebuilds a DATA_LEN-bit vector.
- The vector is either one-hot at that index or a thermometer mask covering bits 0 through that index.
- Works iteratively with the same dut_start/dut_ready/dut_done handshake as the encoder, so the two can be chained back to back.
- Used to turn encoder results back into bit masks, e.g. for clearing the serviced request.

Parameters:
- DATA_LEN, 8, width of the reconstructed output vector.
- RESULT_LEN, 3, width of the index input; must satisfy 2**RESULT_LEN >= DATA_LEN.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- dut_start  input  1  request; sampled only in IDLE.
- dut_ready  output  1  high while in IDLE.
- dut_done  output  1  one-cycle pulse; data_out and err_f are valid in that cycle.
- idx_in  input  RESULT_LEN  bit index to decode.
- zero_in  input  1  input vector was all-zero; forces output 0.
- mode_in  input  1  0 = one-hot, 1 = thermometer (bits idx..0 set).
- data_out  output  DATA_LEN  decoded vector, registered.
- err_f  output  1  idx_in >= DATA_LEN; registered.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered or decoded from the state register.
- Reset values: state = IDLE, dut_done = 0, data_out = 0, err_f = 0. dut_ready = 1 from the first cycle after reset.
- States:
  - IDLE: dut_ready = 1. On an edge where dut_start = 1, latch idx_in, zero_in and mode_in into idx_r, zero_r and mode_r; next state is LOAD.
  - LOAD: work <= 1 (bit 0 set); cnt <= 0.
    - If zero_r = 1, or idx_r >= DATA_LEN, or idx_r == 0, next state is DONE.
    - Otherwise next state is SHIFT.
  - SHIFT: each cycle cnt <= cnt + 1.
    - One-hot: work <= work << 1.
    - Thermometer: work <= (work << 1) | 1.
    - Leave for DONE when cnt + 1 == idx_r, i.e. after exactly idx_r shifts.
  - DONE: dut_done = 1 for exactly one cycle; next state is IDLE unconditionally.
- Output load: data_out and err_f are loaded on the edge entering DONE and held until the next DONE or reset.
  - zero_r = 1: data_out = 0, err_f = 0. zero_in has priority over an out-of-range index.
  - idx_r >= DATA_LEN: data_out = 0, err_f = 1.
  - Otherwise: data_out = final work value, err_f = 0.
- Latency: call the cycle with dut_start = 1 in IDLE cycle 0.
  - dut_done is high in cycle idx + 2.
  - Zero and error cases complete in cycle 2.
  - Maximum latency is DATA_LEN + 1.
- Handshake:
  - dut_start is ignored outside IDLE. Inputs may change after cycle 0 without effect.
  - dut_start held high gives back-to-back operations with one IDLE cycle between them; the period is idx + 3 cycles.
- Width rules:
  - cnt is RESULT_LEN bits; it never exceeds DATA_LEN - 1, so there is no wrap.
  - Shifted-out bits are discarded; in-range indices never shift out.
- Reset mid-operation:
  - rst = 1 in any state aborts the operation.
  - No dut_done is produced; data_out and err_f clear to 0 on that edge.
  - IDLE and dut_ready = 1 follow on the next cycle.
- Simultaneous events: rst wins over dut_start on the same edge.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, then 0 -> dut_ready = 1, data_out = 8'h00, dut_done = 0, err_f = 0.
- One-hot sweep: start with idx_in = 5, mode_in = 0, zero_in = 0 -> dut_done in cycle 7, data_out = 8'h20, err_f = 0. Repeat for idx 0 (done in cycle 2, 8'h01) and idx 7 (done in cycle 9, 8'h80).
- Thermometer: idx_in = 3, mode_in = 1 -> dut_done in cycle 5, data_out = 8'h0F. idx_in = 7 -> 8'hFF.
- Zero and error: zero_in = 1 with idx_in = 6 -> done in cycle 2, data_out = 0, err_f = 0. With DATA_LEN = 6, idx_in = 7 -> done in cycle 2, data_out = 6'h00, err_f = 1.
- Handshake and reset:
  - dut_start held high -> each done is followed by one ready cycle, then the next operation.
  - dut_start pulsed during SHIFT -> ignored.
  - rst = 1 in the 2nd SHIFT cycle of an idx = 6 operation -> no dut_done, data_out = 0, dut_ready = 1 the next cycle.
- Round trip with the encoder: feed encoder result and zero_f into this block (mode 0) for random inputs -> data_out equals the MSB-isolated input, and 0 for an all-zero input.
